// File: rtl/uds_row_serializer.sv
// Downstream UDS stage: captures one wide result frame and streams it out as 256-bit rows
// on a valid/ready interface, dropping (and flagging) frames that arrive while busy.
module uds_row_serializer #(
  parameter int A       = 64,
  parameter int W       = 32,
  parameter int DEPTH   = 8,
  parameter int ROWS_UP = 14,
  parameter int ROWS_DS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2*(A-8)*W-1:0]   i_idata,
  input  logic                   i_idata_valid,
  input  logic [1:0]             i_capt_mode,
  output logic [DEPTH*W-1:0]     o_m_data,
  output logic                   o_m_valid,
  input  logic                   i_m_ready,
  output logic [3:0]             o_m_row,
  output logic                   o_m_last,
  output logic                   o_busy,
  output logic                   o_overflow,
  input  logic                   i_ovf_clr,
  output logic [15:0]            o_frame_cnt
);

  localparam int RW = DEPTH * W;
  localparam int FW = 2 * (A - 8) * W;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          r_state;
  logic [FW-1:0]   r_buf;
  logic [3:0]      r_nrows;
  logic [RW-1:0]   r_m_data;
  logic            r_m_valid;
  logic [3:0]      r_m_row;
  logic            r_m_last;
  logic            r_overflow;
  logic [15:0]     r_frame_cnt;

  logic            w_hs;
  logic            w_capture;
  logic            w_drop;
  logic [3:0]      w_nrowsIn;
  logic [3:0]      w_ptrNext;
  logic [RW-1:0]   w_nextData;
  logic            w_unused;

  // The output row index doubles as the read pointer into the held frame.
  assign w_hs       = r_m_valid && i_m_ready;
  assign w_capture  = i_idata_valid && ((r_state == IDLE) || (w_hs && r_m_last));
  assign w_drop     = i_idata_valid && (r_state == SEND) && !(w_hs && r_m_last);
  assign w_nrowsIn  = i_capt_mode[1] ? 4'(ROWS_UP) : 4'(ROWS_DS);
  assign w_ptrNext  = r_m_row + 4'd1;
  assign w_nextData = r_buf[RW*int'(w_ptrNext) +: RW];
  assign w_unused   = i_capt_mode[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_buf       <= '0;
      r_nrows     <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_m_row     <= '0;
      r_m_last    <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      // A drop in the same cycle as a clear must leave the flag set.
      if (w_drop)
        r_overflow <= 1'b1;
      else if (i_ovf_clr)
        r_overflow <= 1'b0;

      if (w_hs && r_m_last)
        r_frame_cnt <= r_frame_cnt + 16'd1;

      if (w_capture) begin
        r_state   <= SEND;
        r_buf     <= i_idata;
        r_nrows   <= w_nrowsIn;
        r_m_data  <= i_idata[RW-1:0];
        r_m_valid <= 1'b1;
        r_m_row   <= 4'd0;
        r_m_last  <= (w_nrowsIn == 4'd1);
      end else if (w_hs) begin
        if (r_m_last) begin
          r_state   <= IDLE;
          r_m_valid <= 1'b0;
          r_m_row   <= 4'd0;
          r_m_last  <= 1'b0;
        end else begin
          r_m_data  <= w_nextData;
          r_m_row   <= w_ptrNext;
          r_m_last  <= (w_ptrNext == r_nrows - 4'd1);
        end
      end
    end
  end

  assign o_m_data    = r_m_data;
  assign o_m_valid   = r_m_valid;
  assign o_m_row     = r_m_row;
  assign o_m_last    = r_m_last;
  assign o_busy      = (r_state == SEND);
  assign o_overflow  = r_overflow;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_uds_row_serializer.sv
// Scoreboard bench for uds_row_serializer: expected rows are queued when a frame is
// driven and popped as beats are accepted on the output stream.
module tb_uds_row_serializer;

  localparam int FW = 3584;
  localparam int RW = 256;

  typedef struct {
    logic [RW-1:0] data;
    logic [3:0]    row;
    logic          last;
  } beat_t;

  logic            clk;
  logic            rst_n;
  logic [FW-1:0]   i_idata;
  logic            i_idata_valid;
  logic [1:0]      i_capt_mode;
  logic [RW-1:0]   o_m_data;
  logic            o_m_valid;
  logic            i_m_ready;
  logic [3:0]      o_m_row;
  logic            o_m_last;
  logic            o_busy;
  logic            o_overflow;
  logic            i_ovf_clr;
  logic [15:0]     o_frame_cnt;

  beat_t           sbQ[$];
  int              compareCount = 0;
  int              failCount = 0;
  bit              prevStall = 0;
  logic [RW-1:0]   prevData;
  logic [3:0]      prevRow;
  logic            prevLast;
  bit              pat[4];
  int              cyc;

  uds_row_serializer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_idata      (i_idata),
    .i_idata_valid(i_idata_valid),
    .i_capt_mode  (i_capt_mode),
    .o_m_data     (o_m_data),
    .o_m_valid    (o_m_valid),
    .i_m_ready    (i_m_ready),
    .o_m_row      (o_m_row),
    .o_m_last     (o_m_last),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow),
    .i_ovf_clr    (i_ovf_clr),
    .o_frame_cnt  (o_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    compareCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] randFrame();
    logic [FW-1:0] f;
    for (int i = 0; i < 112; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  // Pulses idata_valid for one cycle; accepted frames queue their expected rows.
  task automatic applyStimulus(input logic [FW-1:0] frame, input logic [1:0] mode,
                               input bit accept, input bit clr);
    int    nrows;
    beat_t b;
    nrows = mode[1] ? 14 : 4;
    i_idata       = frame;
    i_capt_mode   = mode;
    i_idata_valid = 1'b1;
    i_ovf_clr     = clr;
    if (accept) begin
      for (int r = 0; r < nrows; r++) begin
        b.data = frame[r*RW +: RW];
        b.row  = 4'(r);
        b.last = (r == nrows - 1);
        sbQ.push_back(b);
      end
    end
    @(posedge clk); #1;
    i_idata_valid = 1'b0;
    i_ovf_clr     = 1'b0;
    i_capt_mode   = ~mode;
    if (accept) begin
      checkOutput("firstBeatValid", RW'(o_m_valid), RW'(1));
      checkOutput("firstBeatRow", RW'(o_m_row), RW'(0));
    end
  endtask

  task automatic runUntilEmpty(input bit bp, input int budget, output int cycles);
    cycles = 0;
    while (sbQ.size() != 0 && cycles < budget) begin
      i_m_ready = bp ? pat[cycles % 4] : 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    if (sbQ.size() != 0) checkOutput("drainTimeout", RW'(sbQ.size()), RW'(0));
  endtask

  task automatic checkIdle(input int expCnt);
    @(posedge clk); #1;
    checkOutput("idleValid", RW'(o_m_valid), RW'(0));
    checkOutput("idleBusy", RW'(o_busy), RW'(0));
    checkOutput("frameCnt", RW'(o_frame_cnt), RW'(expCnt));
  endtask

  // Output monitor: scoreboard pop on every accepted beat, plus hold check while stalled.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prevStall = 0;
    end else begin
      if (prevStall && o_m_valid) begin
        checkOutput("holdData", o_m_data, prevData);
        checkOutput("holdRow", RW'(o_m_row), RW'(prevRow));
        checkOutput("holdLast", RW'(o_m_last), RW'(prevLast));
      end
      if (o_m_valid && i_m_ready) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedBeat", RW'(1), RW'(0));
        end else begin
          e = sbQ.pop_front();
          checkOutput("beatData", o_m_data, e.data);
          checkOutput("beatRow", RW'(o_m_row), RW'(e.row));
          checkOutput("beatLast", RW'(o_m_last), RW'(e.last));
        end
      end
      prevStall = o_m_valid && !i_m_ready;
      prevData  = o_m_data;
      prevRow   = o_m_row;
      prevLast  = o_m_last;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [FW-1:0] f;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    rst_n = 1'b0; i_idata = '0; i_idata_valid = 1'b0; i_capt_mode = 2'b00;
    i_m_ready = 1'b1; i_ovf_clr = 1'b0;
    #12;
    checkOutput("rstValid", RW'(o_m_valid), RW'(0));
    checkOutput("rstRow", RW'(o_m_row), RW'(0));
    checkOutput("rstLast", RW'(o_m_last), RW'(0));
    checkOutput("rstBusy", RW'(o_busy), RW'(0));
    checkOutput("rstOvf", RW'(o_overflow), RW'(0));
    checkOutput("rstCnt", RW'(o_frame_cnt), RW'(0));
    checkOutput("rstData", o_m_data, '0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] upsample counting frame");
    for (int k = 0; k < 112; k++) f[k*32 +: 32] = 32'(k);
    applyStimulus(f, 2'b10, 1, 0);
    checkOutput("row0Item1", RW'(o_m_data[63:32]), RW'(1));
    runUntilEmpty(0, 100, cyc);
    checkOutput("upBeatCycles", RW'(cyc), RW'(14));
    checkIdle(1);

    $display("[TB] downsample frame");
    applyStimulus(randFrame(), 2'b00, 1, 0);
    runUntilEmpty(0, 100, cyc);
    checkOutput("dsBeatCycles", RW'(cyc), RW'(4));
    checkIdle(2);

    $display("[TB] back-pressure");
    applyStimulus(randFrame(), 2'b11, 1, 0);
    runUntilEmpty(1, 200, cyc);
    checkOutput("bpCycles", RW'(cyc), RW'(28));
    checkIdle(3);

    $display("[TB] back-to-back frames");
    i_m_ready = 1'b1;
    applyStimulus(randFrame(), 2'b01, 1, 0);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("b2bLastBefore", RW'(o_m_last), RW'(1));
    checkOutput("b2bCntBefore", RW'(o_frame_cnt), RW'(3));
    applyStimulus(randFrame(), 2'b10, 1, 0);
    checkOutput("b2bCntAfter", RW'(o_frame_cnt), RW'(4));
    runUntilEmpty(0, 100, cyc);
    checkIdle(5);

    $display("[TB] drop and overflow");
    applyStimulus(randFrame(), 2'b10, 1, 0);
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("dropAtRow", RW'(o_m_row), RW'(5));
    applyStimulus(randFrame(), 2'b00, 0, 0);
    checkOutput("ovfSet", RW'(o_overflow), RW'(1));
    i_m_ready = 1'b0;
    applyStimulus(randFrame(), 2'b10, 0, 1);
    checkOutput("ovfSetBeatsClr", RW'(o_overflow), RW'(1));
    i_ovf_clr = 1'b1;
    @(posedge clk); #1;
    i_ovf_clr = 1'b0;
    checkOutput("ovfCleared", RW'(o_overflow), RW'(0));
    checkOutput("stallRow", RW'(o_m_row), RW'(6));
    runUntilEmpty(1, 200, cyc);
    checkIdle(6);

    $display("[TB] reset mid-frame");
    i_m_ready = 1'b1;
    applyStimulus(randFrame(), 2'b10, 1, 0);
    repeat (7) begin @(posedge clk); #1; end
    checkOutput("rstAtRow", RW'(o_m_row), RW'(7));
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", RW'(o_m_valid), RW'(0));
    checkOutput("midRstBusy", RW'(o_busy), RW'(0));
    checkOutput("midRstCnt", RW'(o_frame_cnt), RW'(0));
    sbQ.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("postRstValid", RW'(o_m_valid), RW'(0));
    applyStimulus(randFrame(), 2'b00, 1, 0);
    runUntilEmpty(0, 100, cyc);
    checkIdle(1);
    checkOutput("queueEmpty", RW'(sbQ.size()), RW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
